// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RISC-V core: operand forwarding selects, load-use
// bubbles, taken-branch flushes and data-memory wait stalls with a timeout pulse.
// Instruction type codes: 0 R/bubble, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 UPPER.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [4:0] iRs1D,
  input  logic [4:0] iRs2D,
  input  logic [4:0] iRdD,
  input  logic       iRegWriteD,
  input  logic [2:0] iInstructionTypeD,
  input  logic       iPcSrcE,
  input  logic       iMemReadyM,
  output logic [1:0] oForwardAluOp1E,
  output logic [1:0] oForwardAluOp2E,
  output logic       oStallF,
  output logic       oStallD,
  output logic       oStallE,
  output logic       oStallM,
  output logic       oFlushD,
  output logic       oFlushE,
  output logic       oFlushW,
  output logic       oMemTimeout
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] TYPE_BUBBLE = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_LOAD   = 3'd2;
  localparam logic [TYPE_W-1:0] TYPE_STORE  = 3'd3;
  localparam logic [TYPE_W-1:0] TYPE_UPPER  = 3'd6;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_cnt;

  logic [REG_W-1:0]  rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  logic [REG_W-1:0]  rd_e_q, rd_e_d, rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic              we_e_q, we_e_d, we_m_q, we_m_d, we_w_q, we_w_d;
  logic [TYPE_W-1:0] type_e_q, type_e_d, type_m_q, type_m_d, type_w_q, type_w_d;

  logic mem_wait, load_use, load_stall, branch_flush, flush_e;

  // Forward select for one E operand; the younger M producer wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0]  rs,
    input logic              we_m,
    input logic [REG_W-1:0]  rd_m,
    input logic [TYPE_W-1:0] type_m,
    input logic              we_w,
    input logic [REG_W-1:0]  rd_w,
    input logic [TYPE_W-1:0] type_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (we_m && (rd_m == rs)) begin
        sel = (type_m == TYPE_UPPER) ? 2'b11 : 2'b01;
      end else if (we_w && (rd_w == rs)) begin
        sel = (type_w == TYPE_UPPER) ? 2'b11 : 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin : forward_sel
    oForwardAluOp1E = fwd_sel(rs1_e_q, we_m_q, rd_m_q, type_m_q, we_w_q, rd_w_q, type_w_q);
    oForwardAluOp2E = fwd_sel(rs2_e_q, we_m_q, rd_m_q, type_m_q, we_w_q, rd_w_q, type_w_q);
  end

  // Hazard detection, stall/flush outputs, wait counter and state sequencing.
  always_comb begin : hazard_ctrl
    state_d     = RUN;
    cnt_d       = '0;
    oStallF     = 1'b0;
    oStallD     = 1'b0;
    oStallE     = 1'b0;
    oStallM     = 1'b0;
    oFlushD     = 1'b0;
    oFlushE     = 1'b0;
    oFlushW     = 1'b0;
    oMemTimeout = 1'b0;

    mem_wait     = ((type_m_q == TYPE_LOAD) || (type_m_q == TYPE_STORE)) && !iMemReadyM;
    load_use     = (type_e_q == TYPE_LOAD) && we_e_q && (rd_e_q != '0) &&
                   ((rd_e_q == iRs1D) || (rd_e_q == iRs2D));
    branch_flush = iPcSrcE && !mem_wait;
    load_stall   = load_use && !mem_wait && !iPcSrcE;
    flush_e      = branch_flush || load_stall;

    // A fresh wait always counts from zero, even if the counter was left non-zero.
    wait_cnt = (state_q == MEM_WAIT) ? cnt_q : '0;

    if (mem_wait) begin
      state_d     = MEM_WAIT;
      oStallF     = 1'b1;
      oStallD     = 1'b1;
      oStallE     = 1'b1;
      oStallM     = 1'b1;
      oFlushW     = 1'b1;
      oMemTimeout = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
      cnt_d       = oMemTimeout ? '0 : wait_cnt + CNT_W'(1);
    end else if (branch_flush) begin
      oFlushD = 1'b1;
      oFlushE = 1'b1;
    end else if (load_stall) begin
      state_d = LOAD_STALL;
      oStallF = 1'b1;
      oStallD = 1'b1;
      oFlushE = 1'b1;
    end
  end

  // Shadow pipeline: frozen E/M with a bubble into W while waiting, else advance.
  always_comb begin : shadow_next
    rs1_e_d  = rs1_e_q;
    rs2_e_d  = rs2_e_q;
    rd_e_d   = rd_e_q;
    we_e_d   = we_e_q;
    type_e_d = type_e_q;
    rd_m_d   = rd_m_q;
    we_m_d   = we_m_q;
    type_m_d = type_m_q;
    rd_w_d   = '0;
    we_w_d   = 1'b0;
    type_w_d = TYPE_BUBBLE;

    if (!mem_wait) begin
      rd_w_d   = rd_m_q;
      we_w_d   = we_m_q;
      type_w_d = type_m_q;
      rd_m_d   = rd_e_q;
      we_m_d   = we_e_q;
      type_m_d = type_e_q;
      if (flush_e) begin
        rs1_e_d  = '0;
        rs2_e_d  = '0;
        rd_e_d   = '0;
        we_e_d   = 1'b0;
        type_e_d = TYPE_BUBBLE;
      end else begin
        rs1_e_d  = iRs1D;
        rs2_e_d  = iRs2D;
        rd_e_d   = iRdD;
        we_e_d   = iRegWriteD;
        type_e_d = iInstructionTypeD;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      rs1_e_q  <= '0;
      rs2_e_q  <= '0;
      rd_e_q   <= '0;
      we_e_q   <= 1'b0;
      type_e_q <= TYPE_BUBBLE;
      rd_m_q   <= '0;
      we_m_q   <= 1'b0;
      type_m_q <= TYPE_BUBBLE;
      rd_w_q   <= '0;
      we_w_q   <= 1'b0;
      type_w_q <= TYPE_BUBBLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs1_e_q  <= rs1_e_d;
      rs2_e_q  <= rs2_e_d;
      rd_e_q   <= rd_e_d;
      we_e_q   <= we_e_d;
      type_e_q <= type_e_d;
      rd_m_q   <= rd_m_d;
      we_m_q   <= we_m_d;
      type_m_q <= type_m_d;
      rd_w_q   <= rd_w_d;
      we_w_q   <= we_w_d;
      type_w_q <= type_w_d;
    end
  end

endmodule
